// File: rtl/sv_mm_iter_if.sv
// sv_mm_iter_if: operand/result handshake bundle for sv_mm_iter.
// master drives operands and result acceptance; slave is the multiplier.
interface sv_mm_iter_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] q;
  logic [DATA_WIDTH-1:0] x;
  logic [DATA_WIDTH-1:0] y;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] z;

  modport master (
    output in_valid, q, x, y, out_ready,
    input  in_ready, out_valid, z
  );

  modport slave (
    input  in_valid, q, x, y, out_ready,
    output in_ready, out_valid, z
  );
endinterface

// File: rtl/sv_mm_iter.sv
// sv_mm_iter: iterative MSB-first interleaved modular multiplier, z = x*y mod q.
// Optional leading-zero skip of y when SV_MM_ITER_SKIP_LZ_EN is defined.
module sv_mm_iter #(
  parameter int DATA_WIDTH = 128,
  parameter int STEPS      = 1
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] q_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] z_o
);

  localparam int N  = DATA_WIDTH / STEPS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] NCNT = CW'(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  if (DATA_WIDTH % STEPS != 0) begin : g_chk
    $error("sv_mm_iter: STEPS must divide DATA_WIDTH");
  end

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] q_q, q_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic [DATA_WIDTH-1:0] z_q, z_d;
  logic [DATA_WIDTH-1:0] zo_q, zo_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] zc;
  logic [DATA_WIDTH-1:0] y_load;
  logic [CW-1:0]         cnt_load;

  // one double-and-conditional-add step, each in DATA_WIDTH+1 bits
  function automatic logic [DATA_WIDTH-1:0] mm_step(
    input logic [DATA_WIDTH-1:0] z,
    input logic [DATA_WIDTH-1:0] x,
    input logic [DATA_WIDTH-1:0] q,
    input logic                  b
  );
    logic [DATA_WIDTH:0] d;
    d = {z, 1'b0};
    if (d >= {1'b0, q}) d = d - {1'b0, q};
    if (b) begin
      d = {1'b0, d[DATA_WIDTH-1:0]} + {1'b0, x};
      if (d >= {1'b0, q}) d = d - {1'b0, q};
    end
    return d[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    zc = z_q;
    for (int i = 0; i < STEPS; i++) begin
      zc = mm_step(zc, x_q, q_q, y_q[DATA_WIDTH-1-i]);
    end
  end

`ifdef SV_MM_ITER_SKIP_LZ_EN
  logic [CW-1:0] lz;
  logic          found;

  // leading zero STEPS-bit chunks contribute nothing while z is still 0
  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found) begin
        if (y_i[i*STEPS +: STEPS] == '0) lz = lz + CW'(1);
        else found = 1'b1;
      end
    end
    y_load   = y_i << (int'(lz) * STEPS);
    cnt_load = (lz == NCNT) ? CW'(1) : NCNT - lz;
  end
`else
  always_comb begin
    y_load   = y_i;
    cnt_load = NCNT;
  end
`endif

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zo_d    = zo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          q_d     = q_i;
          x_d     = x_i;
          y_d     = y_load;
          z_d     = '0;
          cnt_d   = cnt_load;
          state_d = RUN;
        end
      end
      RUN: begin
        z_d   = zc;
        y_d   = y_q << STEPS;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          zo_d    = zc;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      q_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zo_q    <= zo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign z_o         = zo_q;

endmodule

// File: tb/tb_sv_mm_iter.sv
// tb_sv_mm_iter: randomized scoreboard bench for sv_mm_iter (DATA_WIDTH=8).
// Reference is plain x*y mod q; latency from the bit length of y.
module tb_sv_mm_iter;

  localparam int W     = 8;
  localparam int STEPS = 1;

  typedef struct {
    logic [W-1:0] z;
    int           lat;
    int           t0;
  } exp_t;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  bit   rnd_rdy = 1'b0;
  logic man_rdy = 1'b1;
  logic pv = 1'b0;
  logic [W-1:0] held = '0;
  exp_t sb[$];

  sv_mm_iter_if #(.DATA_WIDTH(W)) bus ();

  sv_mm_iter #(
    .DATA_WIDTH(W),
    .STEPS     (STEPS)
  ) dut (
    .clk_i      (clk),
    .arstn_i    (arstn),
    .in_valid_i (bus.in_valid),
    .in_ready_o (bus.in_ready),
    .q_i        (bus.q),
    .x_i        (bus.x),
    .y_i        (bus.y),
    .out_valid_o(bus.out_valid),
    .out_ready_i(bus.out_ready),
    .z_o        (bus.z)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #1;
    bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : man_rdy;
  end

  function automatic logic [W-1:0] ref_z(int qv, int xv, int yv);
    return W'((longint'(xv) * longint'(yv)) % longint'(qv));
  endfunction

  function automatic int ref_lat(int yv);
    int b;
    int v;
`ifdef SV_MM_ITER_SKIP_LZ_EN
    if (yv == 0) return 1;
    b = 0;
    v = yv;
    while (v != 0) begin
      b++;
      v = v >> 1;
    end
    return (b + STEPS - 1) / STEPS;
`else
    b = yv;
    v = b;
    return W / STEPS;
`endif
  endfunction

  task automatic chk(string name, longint act, longint req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // monitor: pop on each rising out_valid, check result, latency and flags
  always @(negedge clk) begin
    exp_t e;
    if (!arstn) begin
      pv = 1'b0;
    end else begin
      if (bus.out_valid && !pv) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("z", bus.z, e.z);
          chk("latency", cyc - e.t0, e.lat);
          held = e.z;
        end
      end else if (bus.out_valid) begin
        chk("z_hold", bus.z, held);
      end
      chk("in_ready", bus.in_ready, (sb.size() == 0) && !bus.out_valid);
      pv = bus.out_valid;
    end
  end

  task automatic issue(input int qv, input int xv, input int yv);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    bus.q = W'(qv);
    bus.x = W'(xv);
    bus.y = W'(yv);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.z   = ref_z(qv, xv, yv);
    e.lat = ref_lat(yv);
    e.t0  = cyc;
    sb.push_back(e);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || bus.out_valid) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int qv;
    bus.in_valid = 1'b0;
    bus.q = '0;
    bus.x = '0;
    bus.y = '0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_z", bus.z, 0);
    @(negedge clk);
    #1 arstn = 1'b1;

    issue(251, 200, 100);
    drain();
    issue(251, 250, 250);
    drain();
    issue(251, 0, 255);
    drain();
    issue(251, 1, 123);
    drain();
    issue(251, 77, 1);
    drain();
    issue(251, 5, 0);
    drain();
    issue(251, 20, 16);
    drain();

    // backpressure: result held while new operands are offered
    man_rdy = 1'b0;
    issue(251, 9, 9);
    for (int t = 0; t < 100 && !bus.out_valid; t++) @(negedge clk);
    bus.q = 8'd13;
    bus.x = 8'd4;
    bus.y = 8'd7;
    bus.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("bp_out_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    man_rdy = 1'b1;
    drain();

    // reset in the middle of RUN
    issue(251, 100, 200);
    repeat (3) @(posedge clk);
    #2 arstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    sb.delete();
    @(negedge clk);
    #1 arstn = 1'b1;
    issue(7, 3, 5);
    drain();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      qv = $urandom_range(2, 255);
      issue(qv, $urandom_range(0, qv - 1), $urandom_range(0, 255));
    end
    drain();
    rnd_rdy = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
